// File: rtl/aes_pkg.sv
// aes_pkg -- shared definitions for the AES-128 AHB slave.
//   * AHB legal-value constants (HSIZE, HBURST, HTRANS)
//   * FSM state enum for the iterative round engine
//   * AES S-box and Rcon tables
//   * helpers for the MixColumns step
package aes_pkg;

  localparam logic [2:0] HSIZE_128     = 3'b100;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon for rounds 1..10, stored at index round-1.
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; byte 0 of the column sits in bits [31:24].
  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox -- combinational 8-bit AES S-box lookup.
// Ports:
//   in_byte  (in,  8) byte to substitute
//   out_byte (out, 8) substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_ahb.sv
// aes_ahb -- AHB-Lite slave wrapping an iterative AES-128 encryptor.
// The first write after reset loads the key; each later write loads a
// plaintext block and starts an 11-cycle encryption. Reads return the most
// recent ciphertext. Only single 128-bit NONSEQ transfers are accepted.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   HSELx           slave select
//   HADDR           address (not decoded)
//   HBURST, HSIZE   must be SINGLE / 128-bit for a legal transfer
//   HMASTLOCK,HPORT ignored
//   HTRANS          only NONSEQ starts a transfer
//   HWRITE          1 = write, 0 = read
//   HWDATA          write data, byte 0 in [127:120]
//   HREADY          bus ready, qualifies address and data phases
//   HRDATA          ciphertext during a read data phase, else 0
//   HREADYOUT       0 while a data phase is stalled by an encryption
//   HRESP           registered ERROR flag for illegal transfers
module aes_ahb
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         HSELx,
  input  logic [31:0]  HADDR,
  input  logic [2:0]   HBURST,
  input  logic         HMASTLOCK,
  input  logic [3:0]   HPORT,
  input  logic [2:0]   HSIZE,
  input  logic [1:0]   HTRANS,
  input  logic         HWRITE,
  input  logic [127:0] HWDATA,
  input  logic         HREADY,
  output logic [127:0] HRDATA,
  output logic         HREADYOUT,
  output logic         HRESP
);

  aes_fsm_e     fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_q, key_d;
  logic         key_loaded_q, key_loaded_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic         pend_valid_q, pend_valid_d;
  logic         pend_write_q, pend_write_d;
  logic         hresp_q, hresp_d;

  logic         busy;
  logic         hreadyout;
  logic         legal;
  logic         illegal;
  logic         addr_accept;
  logic         data_accept;
  logic         key_load;
  logic         pt_load;

  logic [7:0]   sb_out [16];
  logic [7:0]   ksb_out [4];
  logic [31:0]  rot_word;
  logic [3:0]   rcon_idx;
  logic [31:0]  kx_temp;
  logic [127:0] rk_next;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_out;

  logic         unused_inputs;
  assign unused_inputs = ^{HADDR, HMASTLOCK, HPORT};

  // Bus decode. A transfer that is neither legal nor illegal (e.g. IDLE or
  // a well-formed SEQ) is simply ignored.
  assign legal   = HSELx && (HTRANS == HTRANS_NONSEQ) &&
                   (HSIZE == HSIZE_128) && (HBURST == HBURST_SINGLE);
  assign illegal = HSELx && ((HTRANS[1] && ((HSIZE != HSIZE_128) ||
                   (HBURST != HBURST_SINGLE))) || (HTRANS == HTRANS_BUSY));

  // Only a pending data phase is stalled by a running encryption, so an
  // address phase can still be accepted while busy and then waits.
  assign busy        = (fsm_q != ST_IDLE);
  assign hreadyout   = !(busy && pend_valid_q);
  assign addr_accept = legal && HREADY && hreadyout;
  assign data_accept = pend_valid_q && HREADY && hreadyout;
  assign key_load    = data_accept && pend_write_q && !key_loaded_q;
  assign pt_load     = data_accept && pend_write_q && key_loaded_q;

  assign HREADYOUT = hreadyout;
  assign HRESP     = hresp_q;
  assign HRDATA    = (pend_valid_q && !pend_write_q && hreadyout) ? ct_q : '0;

  // SubBytes on the current state, byte i at bits [127-8i -: 8].
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (blk_q[127-8*i -: 8]),
      .out_byte (sb_out[i])
    );
  end

  // ShiftRows (row r rotated left by r) then MixColumns per column.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127-8*(4*c+r) -: 8] = sb_out[4*((c+r)%4)+r];
    end
    assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
  end

  // Key expansion: RotWord + SubWord of the last word of the current round key.
  assign rot_word = {rk_q[23:0], rk_q[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_ksub
    aes_sbox u_ksbox (
      .in_byte  (rot_word[31-8*k -: 8]),
      .out_byte (ksb_out[k])
    );
  end

  assign rcon_idx = (round_q == 4'd0) ? 4'd0 : (round_q - 4'd1);
  assign kx_temp  = {ksb_out[0] ^ RCON[rcon_idx], ksb_out[1], ksb_out[2], ksb_out[3]};

  always_comb begin
    rk_next[127:96] = rk_q[127:96] ^ kx_temp;
    rk_next[95:64]  = rk_q[95:64]  ^ rk_next[127:96];
    rk_next[63:32]  = rk_q[63:32]  ^ rk_next[95:64];
    rk_next[31:0]   = rk_q[31:0]   ^ rk_next[63:32];
  end

  // The final round skips MixColumns.
  assign round_out = ((round_q == LAST_ROUND) ? shifted : mixed) ^ rk_next;

  // AHB phase tracking, key capture and the registered error response.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_write_d = pend_write_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    hresp_d      = illegal;
    if (addr_accept) begin
      pend_valid_d = 1'b1;
      pend_write_d = HWRITE;
    end else if (data_accept) begin
      pend_valid_d = 1'b0;
    end
    if (key_load) begin
      key_d        = HWDATA;
      key_loaded_d = 1'b1;
    end
  end

  // Round engine next-state. The load cycle performs the initial
  // AddRoundKey and seeds the running round key with the stored key.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    blk_d   = blk_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    case (fsm_q)
      ST_IDLE: begin
        if (pt_load) begin
          blk_d   = HWDATA ^ key_q;
          rk_d    = key_q;
          round_d = 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        blk_d = round_out;
        rk_d  = rk_next;
        if (round_q == LAST_ROUND) begin
          round_d = 4'd0;
          fsm_d   = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        ct_d  = blk_q;
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d   = ST_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= ST_IDLE;
      round_q      <= 4'd0;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      blk_q        <= '0;
      rk_q         <= '0;
      ct_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      hresp_q      <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      round_q      <= round_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      blk_q        <= blk_d;
      rk_q         <= rk_d;
      ct_q         <= ct_d;
      pend_valid_q <= pend_valid_d;
      pend_write_q <= pend_write_d;
      hresp_q      <= hresp_d;
    end
  end

endmodule

// File: tb/tb_aes_ahb.sv
// tb_aes_ahb -- self-checking bench for aes_ahb.
// Table-driven HRESP decode vectors and FIPS-197 encryption vectors, plus
// hand-written sequences for stalls, back-to-back writes and mid-round reset.
module tb_aes_ahb;

  logic         clk;
  logic         rst;
  logic         HSELx;
  logic [31:0]  HADDR;
  logic [2:0]   HBURST;
  logic         HMASTLOCK;
  logic [3:0]   HPORT;
  logic [2:0]   HSIZE;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [127:0] HWDATA;
  logic         HREADY;
  logic [127:0] HRDATA;
  logic         HREADYOUT;
  logic         HRESP;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       hsel;
    logic [1:0] htrans;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic       exp_hresp;
  } resp_vec_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } enc_vec_t;

  resp_vec_t rv[9];
  enc_vec_t  ev[2];

  localparam logic [127:0] KEY_B = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PT_B  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] CT_B  = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] CT_C  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  aes_ahb dut (
    .clk       (clk),
    .rst       (rst),
    .HSELx     (HSELx),
    .HADDR     (HADDR),
    .HBURST    (HBURST),
    .HMASTLOCK (HMASTLOCK),
    .HPORT     (HPORT),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a wedged run still ends with a FAIL line.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives the address-phase control signals of the bus.
  task automatic applyStimulus(input logic hsel, input logic [1:0] htrans,
                               input logic [2:0] hsize, input logic [2:0] hburst,
                               input logic hwrite);
    HSELx  = hsel;
    HTRANS = htrans;
    HSIZE  = hsize;
    HBURST = hburst;
    HWRITE = hwrite;
    HADDR  = HADDR + 32'h10;
  endtask

  // Waits at falling edges until HREADYOUT is high; counts stalled cycles.
  task automatic waitReady(input string name, output int stalls);
    stalls = 0;
    @(negedge clk);
    while (!HREADYOUT && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (!HREADYOUT) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout actual=stalled required=ready", name);
    end
  endtask

  // Full single write: address phase, then data phase (possibly stalled).
  task automatic ahbWrite(input logic [127:0] data, output int stalls);
    int dummy;
    applyStimulus(1'b1, 2'b10, 3'b100, 3'b000, 1'b1);
    waitReady("wr_addr", dummy);
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'b00, 3'b100, 3'b000, 1'b0);
    HWDATA = data;
    waitReady("wr_data", stalls);
    @(posedge clk); #1;
    HWDATA = '0;
  endtask

  // Full single read; data and HRESP are sampled in the ready data phase.
  task automatic ahbRead(output logic [127:0] data, output logic resp,
                         output int stalls);
    int dummy;
    applyStimulus(1'b1, 2'b10, 3'b100, 3'b000, 1'b0);
    waitReady("rd_addr", dummy);
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'b00, 3'b100, 3'b000, 1'b0);
    waitReady("rd_data", stalls);
    data = HRDATA;
    resp = HRESP;
    @(posedge clk); #1;
  endtask

  // Synchronous-looking reset pulse with output checks while asserted.
  task automatic doReset(input string tag);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_rst_hresp"}, {127'd0, HRESP}, 128'd0);
    checkOutput({tag, "_rst_hreadyout"}, {127'd0, HREADYOUT}, 128'd1);
    checkOutput({tag, "_rst_hrdata"}, HRDATA, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] rdata;
    logic         rresp;
    int           st;

    checks = 0;
    errors = 0;

    // Test tables: HRESP decode cases (all with HWRITE=1) and FIPS vectors.
    rv[0] = '{"size64",        1'b1, 2'b10, 3'b011, 3'b000, 1'b1};
    rv[1] = '{"clear_nosel",   1'b0, 2'b00, 3'b100, 3'b000, 1'b0};
    rv[2] = '{"burst_incr16",  1'b1, 2'b10, 3'b100, 3'b111, 1'b1};
    rv[3] = '{"busy",          1'b1, 2'b01, 3'b100, 3'b000, 1'b1};
    rv[4] = '{"seq_badburst",  1'b1, 2'b11, 3'b100, 3'b010, 1'b1};
    rv[5] = '{"idle_badsize",  1'b1, 2'b00, 3'b011, 3'b000, 1'b0};
    rv[6] = '{"seq_ok",        1'b1, 2'b11, 3'b100, 3'b000, 1'b0};
    rv[7] = '{"busy_bad",      1'b1, 2'b01, 3'b011, 3'b111, 1'b1};
    rv[8] = '{"nosel_bad",     1'b0, 2'b10, 3'b011, 3'b111, 1'b0};
    ev[0] = '{KEY_B, PT_B, CT_B};
    ev[1] = '{KEY_C, PT_C, CT_C};

    // Reset state.
    HADDR     = 32'h4000_0000;
    HMASTLOCK = 1'b0;
    HPORT     = 4'h3;
    HREADY    = 1'b1;
    HWDATA    = '0;
    applyStimulus(1'b0, 2'b00, 3'b100, 3'b000, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    doReset("init");

    // Error-response decode, one clock edge per vector.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(rv[i].hsel, rv[i].htrans, rv[i].hsize, rv[i].hburst, 1'b1);
      HWDATA = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0000 | 128'(i);
      @(posedge clk); #1;
      checkOutput(rv[i].name, {127'd0, HRESP}, {127'd0, rv[i].exp_hresp});
    end
    applyStimulus(1'b0, 2'b00, 3'b100, 3'b000, 1'b0);

    // Read before any key: zero data, OKAY response, no stall.
    ahbRead(rdata, rresp, st);
    checkOutput("nokey_rdata", rdata, 128'd0);
    checkOutput("nokey_hresp", {127'd0, rresp}, 128'd0);
    checkOutput("nokey_stall", 128'(st), 128'd0);

    // Key load (illegal writes above must not have loaded a key), then
    // plaintext, then a read that stalls for the whole encryption.
    ahbWrite(KEY_B, st);
    checkOutput("key_stall", 128'(st), 128'd0);
    checkOutput("key_hresp", {127'd0, HRESP}, 128'd0);
    ahbWrite(PT_B, st);
    checkOutput("pt_stall", 128'(st), 128'd0);
    ahbRead(rdata, rresp, st);
    checkOutput("fipsb_read_stall", 128'(st), 128'd10);
    checkOutput("fipsb_ct", rdata, CT_B);

    // Back-to-back plaintext writes: the second waits out the first.
    ahbWrite(PT_C, st);
    checkOutput("b2b_first_stall", 128'(st), 128'd0);
    ahbWrite(PT_B, st);
    checkOutput("b2b_second_stall", 128'(st), 128'd10);
    ahbRead(rdata, rresp, st);
    checkOutput("b2b_read_stall", 128'(st), 128'd10);
    checkOutput("b2b_ct", rdata, CT_B);

    // FIPS-197 vectors from a fresh reset each time.
    for (int i = 0; i < 2; i++) begin
      doReset("enc");
      ahbWrite(ev[i].key, st);
      checkOutput("enc_key_stall", 128'(st), 128'd0);
      ahbWrite(ev[i].pt, st);
      ahbRead(rdata, rresp, st);
      checkOutput("enc_ct", rdata, ev[i].ct);
      checkOutput("enc_hresp", {127'd0, rresp}, 128'd0);
    end

    // Reset in the middle of a round: result discarded, key forgotten.
    doReset("mid");
    ahbWrite(KEY_B, st);
    ahbWrite(PT_B, st);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_hresp", {127'd0, HRESP}, 128'd0);
    checkOutput("mid_rst_hreadyout", {127'd0, HREADYOUT}, 128'd1);
    checkOutput("mid_rst_hrdata", HRDATA, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ahbRead(rdata, rresp, st);
    checkOutput("mid_read_zero", rdata, 128'd0);
    checkOutput("mid_read_stall", 128'(st), 128'd0);
    ahbWrite(KEY_C, st);
    checkOutput("mid_rekey_stall", 128'(st), 128'd0);
    ahbWrite(PT_C, st);
    checkOutput("mid_pt_stall", 128'(st), 128'd0);
    ahbRead(rdata, rresp, st);
    checkOutput("mid_ct", rdata, CT_C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_ahb.md
AES_AHB -- requirements
Module: aes_ahb

Interface
REQ-001 SHALL expose one clock and an asynchronous active-high reset, named as the codebase does: clk (in, 1, rising-edge clock for all logic), rst (in, 1, async active-high reset).
REQ-002 HSELx  in  1  slave select.
REQ-003 HADDR  in  32  address; not decoded; any value accepted.
REQ-004 HBURST  in  3  must be 3'b000 (SINGLE).
REQ-005 HMASTLOCK  in  1  ignored.
REQ-006 HPORT  in  4  protection bits; ignored.
REQ-007 HSIZE  in  3  must be 3'b100 (128-bit).
REQ-008 HTRANS  in  2  only 2'b10 (NONSEQ) starts a transfer.
REQ-009 HWRITE  in  1  1 = write, 0 = read.
REQ-010 HWDATA  in  128  write data, byte 0 in bits [127:120].
REQ-011 HREADY  in  1  bus ready; qualifies address and data phases.
REQ-012 HRDATA  out  128  ciphertext read data, same byte order as HWDATA.
REQ-013 HREADYOUT  out  1  0 = slave inserts wait states.
REQ-014 HRESP  out  1  1 = ERROR.

Function
REQ-015 Legal transfer SHALL be HSELx=1, HTRANS=2'b10, HSIZE=3'b100, HBURST=3'b000.
REQ-016 Illegal transfer is HSELx=1, HTRANS[1]=1, and HSIZE or HBURST wrong; HTRANS=2'b01 (BUSY) with HSELx=1 also illegal.
REQ-017 HRESP SHALL be registered: at each clk edge, HRESP <= illegal condition of REQ-016; it clears on the first edge with HSELx=0 or a legal transfer.
REQ-018 Address phase SHALL be captured on a clk edge with a legal transfer, HREADY=1 and HREADYOUT=1, latching HWRITE into a pending-phase register.
REQ-019 Write data phase SHALL sample HWDATA on the first later edge with HREADY=1 and HREADYOUT=1.
REQ-020 The first write after reset SHALL load the 128-bit key register; every later write SHALL load the state register as plaintext and start encryption.
REQ-021 Encryption SHALL be AES-128 (FIPS-197), iterative, one round per cycle: initial AddRoundKey in the load cycle, then rounds 1-10, with round 10 omitting MixColumns.
REQ-022 Round keys SHALL be generated on the fly from the stored key using Rcon 01,02,04,08,10,20,40,80,1B,36; the stored key itself SHALL never be overwritten.
REQ-023 FSM SHALL have three states: IDLE, ROUND (4-bit counter 1..10), DONE.
- IDLE -> ROUND on a plaintext load.
- ROUND advances once per cycle; counter=10 -> DONE.
- DONE -> IDLE after one cycle; ciphertext register updated in DONE.
REQ-024 Busy SHALL mean state is not IDLE; the plaintext load edge to ciphertext valid takes 11 cycles.
REQ-025 While busy, any transfer in its data phase SHALL see HREADYOUT=0; HREADYOUT returns to 1 in the cycle after DONE.
REQ-026 Read data phase SHALL drive HRDATA with the last ciphertext while HREADYOUT=1; before any encryption, HRDATA=0.
REQ-027 A write attempted while busy SHALL be stalled, never dropped or merged.
REQ-028 A read before any key has been loaded SHALL return 0 with HRESP=0.
REQ-029 Illegal transfers SHALL not change key, state or the key-loaded flag.

Reset
REQ-030 rst=1 SHALL asynchronously clear key, state, ciphertext, the key-loaded flag and the pending-phase register; FSM goes to IDLE.
REQ-031 During reset, outputs SHALL be HRESP=0, HREADYOUT=1, HRDATA=0.
REQ-032 Reset during encryption SHALL abort it, discarding the partial result.

Structure
REQ-033 A shared package aes_pkg SHALL hold the S-box table, the Rcon table, the HSIZE/HBURST/HTRANS legal-value constants and the FSM state enum.
REQ-034 A sub-module aes_sbox (8-bit combinational S-box lookup) SHALL be instantiated 20 times: 16 for SubBytes, 4 for key expansion.

Verification
REQ-035 HSIZE=3'b011, legal otherwise, HSELx=1 -> HRESP=1 after the next edge; HBURST=3'b111 -> HRESP=1; HTRANS=2'b01 -> HRESP=1.
REQ-036 Legal write of 2B7E151628AED2A6ABF7158809CF4F3C -> HRESP=0, key loaded, HREADYOUT stays 1.
REQ-037 Then legal write of 3243F6A8885A308D313198A2E0370734, then read -> HREADYOUT=0 while busy, then HRDATA=3925841D02DC09FBDC118597196A0B32.
REQ-038 Key 000102030405060708090A0B0C0D0E0F, plaintext 00112233445566778899AABBCCDDEEFF -> ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A.
REQ-039 Assert rst during ROUND, then a read -> HRDATA=0, and the next write is treated as a key load.
REQ-040 Issue back-to-back plaintext writes -> the second is stalled until DONE, and the read returns the second ciphertext.
